// File: rtl/fifo_read_drainer.sv
// Read-side drainer for async_fifo: paces rd_en against the FIFO flags, absorbs the
// one-cycle read latency and re-presents words on a valid/ready stream.
// state | meaning: IDLE = disabled, nothing pending; RUN = enabled, issuing reads; DRAIN = disabled, finishing work
module fifo_read_drainer #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy,
    output logic                  err_underflow
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cap_q, cap_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

    logic                  push, pop, busy_w, credit_ok;
    logic [OW-1:0]         occ_pre;

    always_comb begin
        state_d    = state_q;
        rd_en_d    = 1'b0;
        push       = cap_q;
        pop        = (occ_q != '0) && out_ready;
        busy_w     = rd_en_q || cap_q || (occ_q != '0);
        // Credit counts the word landing this edge plus the read still on the bus.
        occ_pre    = occ_q + OW'(push);
        credit_ok  = ({1'b0, occ_pre} + (OW+1)'(rd_en_q)) < (OW+1)'(BUF_DEPTH);

        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = busy_w ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (enable)       state_d = S_RUN;
                else if (!busy_w) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Never read back-to-back when the FIFO may hold only one word.
        rd_en_d    = (state_d == S_RUN) && !fifo_empty && credit_ok
                     && !(fifo_almost_empty && rd_en_q);
        cap_d      = rd_en_q;

        occ_d      = occ_pre - OW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);

        out_data_d = out_data_q;
        if (occ_d != '0) begin
            if ((occ_q - OW'(pop)) == '0) out_data_d = fifo_rd_data;
            else                          out_data_d = mem_q[rd_ptr_d];
        end

        cnt_d      = cnt_q + CNT_WIDTH'(push);
        err_d      = err_q || fifo_underflow;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_en_q    <= 1'b0;
            cap_q      <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            cap_q      <= cap_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) mem_q[wr_ptr_q] <= fifo_rd_data;
    end

    assign fifo_rd_en    = rd_en_q;
    assign out_valid     = (occ_q != '0);
    assign out_data      = out_data_q;
    assign rd_count      = cnt_q;
    assign busy          = busy_w;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Scoreboard bench for fifo_read_drainer: a behavioural async_fifo read port feeds the DUT
// and every word popped downstream is matched against the order it was loaded.
module tb_fifo_read_drainer;

    logic       rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic       rst, enable, out_ready;
    logic       fifo_empty, fifo_almost_empty, fifo_underflow;
    logic       force_uf, model_uf;
    logic [7:0] fifo_rd_data;

    wire        fifo_rd_en, out_valid, busy, err_underflow;
    wire [7:0]  out_data;
    wire [15:0] rd_count;
    wire        fifo_rd_en4, out_valid4, busy4, err_underflow4;
    wire [7:0]  out_data4;
    wire [3:0]  rd_count4;

    assign fifo_underflow = model_uf | force_uf;

    fifo_read_drainer #(.DATA_WIDTH(8), .BUF_DEPTH(4), .CNT_WIDTH(16)) u_dut (
        .rd_clk(rd_clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .rd_count(rd_count), .busy(busy),
        .err_underflow(err_underflow)
    );

    // Narrow-counter twin driven by the same stimulus, used for the wrap check.
    fifo_read_drainer #(.DATA_WIDTH(8), .BUF_DEPTH(4), .CNT_WIDTH(4)) u_dut4 (
        .rd_clk(rd_clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .rd_count(rd_count4), .busy(busy4),
        .err_underflow(err_underflow4)
    );

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;
    int         n_vec, n_err, n_reads, gaps;
    bit         seen_first, rd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO flags show the state before this cycle's read; data follows one cycle after rd_en.
    always @(negedge rd_clk) begin
        rd_seen           = fifo_rd_en;
        fifo_empty        = (fifo_q.size() == 0);
        fifo_almost_empty = (fifo_q.size() <= 1);
        if (fifo_rd_en) n_reads++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
            else begin
                exp_word = exp_q.pop_front();
                chk("out_data", out_data, exp_word);
            end
        end
        if (out_valid) seen_first = 1'b1;
        else if (seen_first && exp_q.size() > 0) gaps++;
    end

    always @(posedge rd_clk) begin
        #1;
        model_uf = 1'b0;
        if (rd_seen) begin
            if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            else                   model_uf = 1'b1;
        end
    end

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic apply_reset();
        @(posedge rd_clk); #1 rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input int left, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge rd_clk);
            if (exp_q.size() == left && !busy) break;
        end
        chk({tag, "_left"}, exp_q.size(), left);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_reads = 0; gaps = 0; seen_first = 1'b0; rd_seen = 1'b0;
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1; force_uf = 1'b0; model_uf = 1'b0;
        fifo_empty = 1'b1; fifo_almost_empty = 1'b1; fifo_rd_data = 8'h00;
        load(8'h10, 8);

        // Reset held for three edges with data available and enable high.
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_count4", rd_count4, 0);

        @(posedge rd_clk); #1 rst = 1'b0;
        n_reads = 0; gaps = 0; seen_first = 1'b0;
        @(negedge rd_clk);
        chk("first_rd_early", fifo_rd_en, 0);
        @(negedge rd_clk);
        chk("first_rd", fifo_rd_en, 1);
        wait_drain(0, "stream");
        chk("stream_count", rd_count, 8);
        chk("stream_reads", n_reads, 8);
        chk("stream_gaps", gaps, 0);

        // Backpressure: buffer fills to depth and the head word holds.
        @(posedge rd_clk); #1 out_ready = 1'b0;
        n_reads = 0;
        load(8'h20, 10);
        repeat (15) @(negedge rd_clk);
        chk("bp_reads", n_reads, 4);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, 8'h20);
        repeat (3) @(negedge rd_clk);
        chk("bp_hold", out_data, 8'h20);
        @(posedge rd_clk); #1 out_ready = 1'b1;
        wait_drain(0, "bp");
        chk("bp_count", rd_count, 18);
        chk("bp_reads_total", n_reads, 10);

        // Single remaining word must be read exactly once.
        apply_reset();
        n_reads = 0;
        load(8'h33, 1);
        wait_drain(0, "pace");
        repeat (5) @(negedge rd_clk);
        chk("pace_reads", n_reads, 1);
        chk("pace_uf", err_underflow, 0);
        chk("pace_count", rd_count, 1);

        // Drop enable in the cycle the read is issued; that word still completes.
        @(posedge rd_clk); #1 enable = 1'b0;
        load(8'h40, 6);
        @(posedge rd_clk); #1 enable = 1'b1;
        n_reads = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge rd_clk); #1;
            if (fifo_rd_en) break;
        end
        enable = 1'b0;
        @(negedge rd_clk);
        chk("dis_busy", busy, 1);
        wait_drain(5, "dis");
        repeat (5) @(negedge rd_clk);
        chk("dis_reads", n_reads, 1);
        chk("dis_count", rd_count, 2);
        @(posedge rd_clk); #1 enable = 1'b1;
        wait_drain(0, "resume");
        chk("resume_count", rd_count, 7);

        // Sticky underflow and counter wrap.
        apply_reset();
        @(posedge rd_clk); #1 force_uf = 1'b1;
        @(posedge rd_clk); #1 force_uf = 1'b0;
        @(negedge rd_clk);
        chk("err_set", err_underflow, 1);
        load(8'h50, 17);
        wait_drain(0, "wrap");
        chk("wrap_count", rd_count, 17);
        chk("wrap_count4", rd_count4, 1);
        chk("err_sticky", err_underflow, 1);
        apply_reset();
        @(negedge rd_clk);
        chk("err_cleared", err_underflow, 0);
        chk("count_cleared", rd_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_drainer.md
Name: fifo_read_drainer

Overview:
- Read-side controller for async_fifo, in the rd_clk domain.
- Pulls words out of the FIFO by driving rd_en against the empty/almost_empty flags, absorbing the FIFO's one-cycle read latency.
- Presents the words on a valid/ready output stream through a small credit-checked buffer.
- Counts drained words and flags any underflow the FIFO reports.

Parameters:
- DATA_WIDTH, 8, width of FIFO read data and output data
- BUF_DEPTH, 4, output buffer entries; power of two, minimum 2
- CNT_WIDTH, 16, width of drained-word counter

Ports:
- rd_clk  input  1  single clock, FIFO read clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = issue reads when data is available
- fifo_empty  input  1  async_fifo empty
- fifo_almost_empty  input  1  async_fifo almost_empty (1 = at most one word left)
- fifo_underflow  input  1  async_fifo underflow
- fifo_rd_data  input  DATA_WIDTH  async_fifo rd_data, valid one cycle after fifo_rd_en
- fifo_rd_en  output  1  read strobe to async_fifo
- out_valid  output  1  output word available
- out_ready  input  1  downstream accepts word
- out_data  output  DATA_WIDTH  head-of-buffer word
- rd_count  output  CNT_WIDTH  words captured since reset
- busy  output  1  read in flight or buffer non-empty
- err_underflow  output  1  sticky underflow seen

Behaviour:
- Single clock domain rd_clk; reset rst is synchronous and active-high.
- While rst=1 at a rising edge, the following are all 0 from the next edge onward:
  - fifo_rd_en, out_valid, out_data, rd_count, busy, err_underflow
  - buffer occupancy, pointers, in-flight flag
- Reset mid-operation discards buffered words and any in-flight read; a word returned the cycle after reset is ignored.
- fifo_rd_en is registered. Issue condition for cycle N+1, evaluated at edge N:
  - enable=1
  - fifo_empty=0
  - occ + inflight_next < BUF_DEPTH. occ is the occupancy before this cycle's pop; a pop in the same cycle earns no credit.
  - Pacing: if fifo_almost_empty=1, issue only if fifo_rd_en was 0 in the current cycle (no back-to-back reads on the last word).
- Read latency:
  - fifo_rd_en high in cycle N; fifo_rd_data sampled at the end of cycle N+1 and written to the buffer tail.
  - out_valid is high in cycle N+2 if the buffer was empty.
  - Minimum enable-to-out_valid latency is 3 cycles.
- The in-flight flag is set by fifo_rd_en and cleared on capture. The credit rule guarantees a capture never finds the buffer full.
- Buffer is a circular buffer of BUF_DEPTH entries.
  - Pointers wrap modulo BUF_DEPTH; occupancy is held in clog2(BUF_DEPTH)+1 bits.
  - out_data is the head entry, registered and stable while out_valid=1 and out_ready=0.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - A push into an empty buffer gives out_valid the next cycle; there is no combinational bypass.
- rd_count increments by 1 on each capture and wraps to 0 after 2^CNT_WIDTH-1.
- enable deasserted: no new reads. An in-flight read still completes and the buffer keeps draining to downstream.
- busy = inflight || (occ != 0).
- err_underflow is set when fifo_underflow=1 at any edge and cleared only by rst.
- State machine:
  - IDLE: enable=0 and !busy.
  - RUN: enable=1.
  - DRAIN: enable=0 and busy.
  - Transitions: IDLE->RUN on enable; RUN->DRAIN on !enable && busy; RUN->IDLE on !enable && !busy; DRAIN->IDLE when !busy; DRAIN->RUN on enable.
  - Reads are issued only in RUN.

Test Plan:
- Reset: hold rst for 3 edges with fifo_empty=0 and enable=1 -> fifo_rd_en, out_valid, rd_count, busy, err_underflow all 0; first fifo_rd_en appears the cycle after rst falls.
- Streaming: FIFO holds 8 words 0x10..0x17, out_ready=1, BUF_DEPTH=4 -> out_data sequence 0x10..0x17 in order, no gaps after the first, rd_count=8, busy returns to 0.
- Backpressure: out_ready=0 with 10 words available -> exactly 4 reads issued, out_valid=1, out_data=first word stable. Raise out_ready -> remaining 6 words delivered in order.
- Last-word pacing: FIFO holds 1 word (almost_empty=1, empty=0) -> exactly one fifo_rd_en pulse, no second read, fifo_underflow stays 0, rd_count=1.
- Disable mid-stream: drop enable the cycle a read is issued -> that word is still captured and delivered, no further fifo_rd_en, state DRAIN->IDLE once the buffer empties.
- Error and wrap: pulse fifo_underflow once -> err_underflow=1 until rst. With CNT_WIDTH=4, capture 17 words -> rd_count=1.
